// File: rtl/fft_capture_sequencer.sv
// fft_capture_sequencer
//
// Runs one tone-identification pass. While the record button is held,
// decimated samples go into a circular buffer. On release, exactly one
// FFT frame of FFT_LENGTH words is streamed to the FFT core over a
// valid/ready handshake. The block then waits for the FFT output frame
// to end, pulses done_out and returns to idle.
//
// Configuration macro: FFT_SEQ_ZEROPAD_EN
//   defined   - a partial recording (count < FFT_LENGTH) is streamed with
//               zero padding after the last recorded sample.
//   undefined - a partial recording is rejected with an error_out pulse.
//               Only a full buffer is streamed.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   enable_in               recording may start only while high
//   record_in               debounced record button (level)
//   sample_valid_in/_in     one-cycle strobe plus signed sample
//   fft_t*_out, fft_tready  FFT input stream, tdata = {imag=0, real}
//   fft_out_valid/last_in   FFT output beat, used to detect frame end
//   busy_out, state_out     status (state: 0 idle .. 4 done)
//   done_out, error_out     one-cycle result pulses
module fft_capture_sequencer #(
  parameter int FFT_LENGTH     = 1024,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           enable_in,
  input  logic                           record_in,
  input  logic                           sample_valid_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  output logic [2*SAMPLE_WIDTH-1:0]      fft_tdata_out,
  output logic                           fft_tvalid_out,
  output logic                           fft_tlast_out,
  input  logic                           fft_tready_in,
  input  logic                           fft_out_valid_in,
  input  logic                           fft_out_last_in,
  output logic                           busy_out,
  output logic [2:0]                     state_out,
  output logic                           done_out,
  output logic                           error_out
);

  localparam int AW = $clog2(FFT_LENGTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   LEN      = (AW + 1)'(FFT_LENGTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LENGTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RECORD   = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_FFT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              rec_prev_q;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW:0]       count_q, count_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
  // Output stage: vld_q/idx_q/pad_q describe the word held in rd_data_q.
  logic              vld_q, vld_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              pad_q, pad_d;
  logic [AW-1:0]     rd_idx;
  logic [AW-1:0]     rd_addr;
  logic              wr_en;
  logic              full;
  logic              rec_rise;

  logic signed [SAMPLE_WIDTH-1:0] mem_q [FFT_LENGTH];
  logic signed [SAMPLE_WIDTH-1:0] rd_data_q;

  assign full     = (count_q == LEN);
  assign rec_rise = record_in && !rec_prev_q;
  // Oldest sample first once the buffer has wrapped.
  assign rd_addr  = (full ? wptr_q : {AW{1'b0}}) + rd_idx;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    tmo_d   = '0;
    err_d   = 1'b0;
    vld_d   = vld_q;
    idx_d   = idx_q;
    pad_d   = pad_q;
    rd_idx  = idx_q;
    wr_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        vld_d = 1'b0;
        if (enable_in && rec_rise) begin
          state_d = S_RECORD;
          wptr_d  = '0;
          count_d = '0;
        end
      end

      S_RECORD: begin
        if (sample_valid_in) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (!full) count_d = count_q + 1'b1;
        end
        // count_d includes a strobe that lands in the release cycle.
        if (!record_in) begin
          if (count_d == '0) begin
            state_d = S_IDLE;
          end
`ifdef FFT_SEQ_ZEROPAD_EN
          else begin
            state_d = S_STREAM;
          end
`else
          else if (count_d == LEN) begin
            state_d = S_STREAM;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
`endif
        end
      end

      S_STREAM: begin
        // A stalled word is simply re-read from the same address, so the
        // read register doubles as the skid stage and data holds stable.
        if (!vld_q) begin
          rd_idx = '0;
          vld_d  = 1'b1;
        end else if (fft_tready_in) begin
          if (idx_q == LAST_IDX) begin
            vld_d   = 1'b0;
            state_d = S_WAIT_FFT;
          end else begin
            rd_idx = idx_q + 1'b1;
          end
        end
        idx_d = rd_idx;
        pad_d = ({1'b0, rd_idx} >= count_q);
      end

      S_WAIT_FFT: begin
        tmo_d = tmo_q + 1'b1;
        if (fft_out_valid_in && fft_out_last_in) begin
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      rec_prev_q <= 1'b0;
      wptr_q     <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      pad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rec_prev_q <= record_in;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
      idx_q      <= idx_d;
      pad_q      <= pad_d;
    end
  end

  // Sample buffer: single write port, registered read every cycle.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wptr_q] <= sample_in;
    rd_data_q <= mem_q[rd_addr];
  end

  assign fft_tvalid_out = vld_q;
  assign fft_tlast_out  = vld_q && (idx_q == LAST_IDX);
  assign fft_tdata_out  = (vld_q && !pad_q) ? {{SAMPLE_WIDTH{1'b0}}, rd_data_q}
                                            : {2*SAMPLE_WIDTH{1'b0}};
  assign busy_out       = (state_q != S_IDLE);
  assign state_out      = state_q;
  assign done_out       = (state_q == S_DONE);
  assign error_out      = err_q;

endmodule
